// File: rtl/morse_decoder.sv
// morse_decoder: receive side of the lab Morse link.
//
// Samples a single on/off Morse line on a free-running tick, classifies mark runs as dot or
// dash, assembles up to four symbols and decodes the letters A..H back to a 3-bit code
// (0 = A .. 7 = H).
//
// Ports:
//   CLOCK_50      in   system clock
//   KEY0          in   asynchronous active-low reset
//   morse_in      in   Morse line, 1 = mark, asynchronous to CLOCK_50
//   letter_out    out  last decoded letter, held until the next valid letter
//   letter_valid  out  one-cycle pulse, letter_out updated in this cycle
//   letter_err    out  error indication (illegal pattern, >4 symbols, or over-long mark)
//   busy          out  high while a letter is being assembled
//   sym_count     out  symbols captured so far in the current letter (0..4)
//
// Configuration macro:
//   MORSE_DEC_STICKY_ERR_EN  defined   -> letter_err is a level, set on any error and cleared
//                                         only by the next letter_valid or by reset
//                            undefined -> letter_err is a one-cycle pulse

module morse_decoder #(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned DASH_MIN   = 2,
    parameter int unsigned MARK_MAX   = 4,
    parameter int unsigned LETTER_GAP = 3
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       morse_in,
    output logic [2:0] letter_out,
    output logic       letter_valid,
    output logic       letter_err,
    output logic       busy,
    output logic [2:0] sym_count
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RunTop = (MARK_MAX + 1 > LETTER_GAP) ? MARK_MAX + 1 : LETTER_GAP;
    localparam int unsigned RunW   = $clog2(RunTop + 1);

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [RunW-1:0]  RunOne   = RunW'(1);
    localparam logic [RunW-1:0]  RunSat   = RunW'(MARK_MAX + 1);
    localparam logic [RunW-1:0]  RunLong  = RunW'(MARK_MAX);
    localparam logic [RunW-1:0]  RunDash  = RunW'(DASH_MIN);
    localparam logic [RunW-1:0]  RunGap   = RunW'(LETTER_GAP);

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace
    } state_e;

    // ------------------------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       sample;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], morse_in};
        end
    end

    assign sample = sync_q[1];

    // ------------------------------------------------------------------------------------
    // Free-running tick divider
    // ------------------------------------------------------------------------------------
    logic [TickW-1:0] tick_cnt_q;
    logic             tick;

    assign tick = (tick_cnt_q == TickLast);

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    // ------------------------------------------------------------------------------------
    // Letter decode
    // ------------------------------------------------------------------------------------
    // The shift register is cleared at the start of every letter and symbols enter at the
    // LSB, so the first symbol sits at bit (count-1) and unused upper bits are zero.
    // Returns {match, letter}.
    function automatic logic [3:0] decode(input logic [2:0] cnt, input logic [3:0] pat);
        logic [3:0] res;
        res = 4'b0000;
        case ({cnt, pat})
            {3'd2, 4'b0001}: res = {1'b1, 3'd0};  // A .-
            {3'd4, 4'b1000}: res = {1'b1, 3'd1};  // B -...
            {3'd4, 4'b1010}: res = {1'b1, 3'd2};  // C -.-.
            {3'd3, 4'b0100}: res = {1'b1, 3'd3};  // D -..
            {3'd1, 4'b0000}: res = {1'b1, 3'd4};  // E .
            {3'd4, 4'b0010}: res = {1'b1, 3'd5};  // F ..-.
            {3'd3, 4'b0110}: res = {1'b1, 3'd6};  // G --.
            {3'd4, 4'b0000}: res = {1'b1, 3'd7};  // H ....
            default:         res = 4'b0000;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------------------------
    // Classifier FSM
    // ------------------------------------------------------------------------------------
    state_e          state_q;
    logic [RunW-1:0] run_q;
    logic [3:0]      shift_q;
    logic [2:0]      sym_count_q;
    logic            bad_q;      // fifth symbol seen: letter will decode as an error
    logic            swallow_q;  // over-long mark already reported: drop the rest silently

    logic [RunW-1:0] run_inc;
    logic            sym_bit;
    logic            dec_ok;
    logic [2:0]      dec_letter;

    always_comb begin
        run_inc               = run_q + RunOne;
        sym_bit               = (run_q >= RunDash);
        {dec_ok, dec_letter}  = decode(sym_count_q, shift_q);
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q      <= StIdle;
            run_q        <= '0;
            shift_q      <= '0;
            sym_count_q  <= '0;
            bad_q        <= 1'b0;
            swallow_q    <= 1'b0;
            letter_out   <= '0;
            letter_valid <= 1'b0;
            letter_err   <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
`ifndef MORSE_DEC_STICKY_ERR_EN
            letter_err   <= 1'b0;
`endif
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (sample) begin
                            state_q <= StMark;
                            run_q   <= RunOne;
                        end
                    end

                    StMark: begin
                        if (sample) begin
                            if (run_q < RunSat) begin
                                run_q <= run_inc;
                            end
                        end else begin
                            state_q <= StSpace;
                            run_q   <= RunOne;
                            if (run_q > RunLong) begin
                                letter_err  <= 1'b1;
                                swallow_q   <= 1'b1;
                                shift_q     <= '0;
                                sym_count_q <= '0;
                                bad_q       <= 1'b0;
                            end else if (sym_count_q == 3'd4) begin
                                bad_q <= 1'b1;
                            end else begin
                                shift_q     <= {shift_q[2:0], sym_bit};
                                sym_count_q <= sym_count_q + 3'd1;
                            end
                        end
                    end

                    StSpace: begin
                        if (sample) begin
                            state_q <= StMark;
                            run_q   <= RunOne;
                        end else if (run_inc >= RunGap) begin
                            state_q     <= StIdle;
                            run_q       <= '0;
                            shift_q     <= '0;
                            sym_count_q <= '0;
                            bad_q       <= 1'b0;
                            swallow_q   <= 1'b0;
                            if (!swallow_q) begin
                                if (dec_ok && !bad_q) begin
                                    letter_valid <= 1'b1;
                                    letter_out   <= dec_letter;
`ifdef MORSE_DEC_STICKY_ERR_EN
                                    letter_err   <= 1'b0;
`endif
                                end else begin
                                    letter_err <= 1'b1;
                                end
                            end
                        end else begin
                            run_q <= run_inc;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: randomized letters against a dot/dash string model with a scoreboard.

module tb_morse_decoder;

    localparam int unsigned TD         = 3;
    localparam int unsigned DASH_MIN   = 2;
    localparam int unsigned MARK_MAX   = 4;
    localparam int unsigned LETTER_GAP = 3;

    logic       clk;
    logic       KEY0;
    logic       morse_in;
    logic [2:0] letter_out;
    logic       letter_valid;
    logic       letter_err;
    logic       busy;
    logic [2:0] sym_count;

    morse_decoder #(
        .TICK_DIV   (TD),
        .DASH_MIN   (DASH_MIN),
        .MARK_MAX   (MARK_MAX),
        .LETTER_GAP (LETTER_GAP)
    ) dut (
        .CLOCK_50     (clk),
        .KEY0         (KEY0),
        .morse_in     (morse_in),
        .letter_out   (letter_out),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .busy         (busy),
        .sym_count    (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit       is_err;
        bit [2:0] letter;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    string morse_tab[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Each value is held for a whole tick period, so every tick sees exactly one of them.
    task automatic drive(input bit v, input int ticks);
        morse_in = v;
        repeat (ticks * TD) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: marks of 1..DASH_MIN-1 ticks are dots, up to MARK_MAX dashes, longer ones
    // each report an error and void the letter; otherwise the dot/dash string is looked up.
    task automatic model_push(input int lens[$]);
        string s;
        int    nlong;
        exp_t  e;
        s     = "";
        nlong = 0;
        foreach (lens[i]) begin
            if (lens[i] > int'(MARK_MAX)) nlong++;
            else if (lens[i] < int'(DASH_MIN)) s = {s, "."};
            else s = {s, "-"};
        end
        if (nlong > 0) begin
            repeat (nlong) begin
                e.is_err = 1'b1;
                e.letter = 3'd0;
                exp_q.push_back(e);
            end
        end else begin
            e.is_err = 1'b1;
            e.letter = 3'd0;
            for (int k = 0; k < 8; k++) begin
                if (s == morse_tab[k]) begin
                    e.is_err = 1'b0;
                    e.letter = 3'(k);
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_letter(input int lens[$], input int gap);
        model_push(lens);
        foreach (lens[i]) begin
            drive(1'b1, lens[i]);
            if (i < lens.size() - 1) drive(1'b0, int'($urandom_range(1, 2)));
            else drive(1'b0, gap);
        end
        drive(1'b0, 1);
        check("busy_after_letter", int'(busy), 0);
        check("sym_count_after_letter", int'(sym_count), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a letter result.
    initial begin : monitor
        logic [2:0] held_exp;
        bit         after_evt;
        exp_t       e;
        held_exp  = 3'd0;
        after_evt = 1'b0;
        forever begin
            @(negedge clk);
            if (!KEY0) begin
                held_exp  = 3'd0;
                after_evt = 1'b0;
            end else if (after_evt) begin
                check("pulse_width", int'(letter_valid) + int'(letter_err), 0);
                after_evt = 1'b0;
            end else if (letter_valid || letter_err) begin
                after_evt = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'(letter_valid) + int'(letter_err), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_err", int'(letter_err), int'(e.is_err));
                    check("event_valid", int'(letter_valid), int'(!e.is_err));
                    if (!e.is_err) held_exp = e.letter;
                    check("letter_out", int'(letter_out), int'(held_exp));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0",
                 exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        KEY0     = 1'b0;
        morse_in = 1'b0;
        #3;
        check("rst_letter_out", int'(letter_out), 0);
        check("rst_letter_valid", int'(letter_valid), 0);
        check("rst_letter_err", int'(letter_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sym_count", int'(sym_count), 0);
        #9;
        KEY0 = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 2);

        // Directed letters
        send_letter('{1, 3}, 3);           // A
        send_letter('{3, 1, 1, 1}, 4);     // B
        send_letter('{1, 1, 1, 1}, 3);     // H
        send_letter('{1, 1, 2, 2}, 3);     // not in table
        send_letter('{1, 1, 1, 1, 1}, 3);  // five symbols
        send_letter('{6}, 3);              // over-long mark
        send_letter('{1}, 3);              // E
        send_letter('{4, 2, 1}, 5);        // G with max-length dash

        // Randomized letters
        for (int n = 0; n < 40; n++) begin
            int    lens[$];
            int    kind;
            int    cnt;
            string pat;
            lens = {};
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                pat = morse_tab[$urandom_range(0, 7)];
                for (int j = 0; j < pat.len(); j++) begin
                    if (pat[j] == ".") lens.push_back(1);
                    else lens.push_back(int'($urandom_range(2, 4)));
                end
            end else begin
                cnt = int'($urandom_range(1, 5));
                for (int j = 0; j < cnt; j++) begin
                    if ($urandom_range(0, 1) == 0) lens.push_back(1);
                    else lens.push_back(int'($urandom_range(2, 4)));
                end
            end
            if (kind == 9) lens[$urandom_range(0, lens.size() - 1)] = int'($urandom_range(5, 7));
            send_letter(lens, int'($urandom_range(3, 5)));
        end

        // Reset in the middle of a letter after two symbols, with a mark in progress
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 2);
        check("mid_sym_count", int'(sym_count), 2);
        check("mid_busy", int'(busy), 1);
        KEY0 = 1'b0;
        #1;
        check("mid_rst_sym_count", int'(sym_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_letter_out", int'(letter_out), 0);
        check("mid_rst_valid", int'(letter_valid), 0);
        check("mid_rst_err", int'(letter_err), 0);
        morse_in = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        KEY0 = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 6);
        check("post_rst_busy", int'(busy), 0);
        send_letter('{1}, 3);              // E after reset

        drive(1'b0, 3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
